line_window_buffer: RTL
=======================

# line_window_buffer

Parametrised multi-line buffer for the Sobel edge-detection pipeline. It accepts a raster pixel stream and, for every accepted pixel, presents a vertical column of ROWS pixels at the same x position: the current pixel plus the pixels from the ROWS-1 preceding lines. A downstream shift-register kernel builds its ROWSxROWS window from this column. Compared with a single fixed-depth line FIFO, this block generalises pixel width, line length and line count, and adds frame restart, coordinates, end-of-line flagging and fill-qualified output valid.

## Interface
- DATA_W, 8, pixel width in bits (>=1)
- LINE_W, 170, pixels per line, i.e. depth of each line store (>=2)
- ROWS, 3, column height in taps, i.e. number of lines (>=2; ROWS-1 line stores)
- Y_W, 16, width of row coordinate output

- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- valid_i  in  1  data_i/sof_i qualifier; one pixel accepted per cycle when high
- sof_i  in  1  start of frame; meaningful only with valid_i; that pixel is (x=0, y=0)
- data_i  in  DATA_W  input pixel
- valid_o  out  1  col_o/x_o/y_o/eol_o valid; single-cycle pulse per qualifying pixel
- col_o  out  ROWS*DATA_W  tap k at [k*DATA_W +: DATA_W]; tap0 = current pixel, tap k = pixel k lines earlier at same x
- x_o  out  clog2(LINE_W)  column of output column
- y_o  out  Y_W  row of tap0
- eol_o  out  1  high with valid_o when x_o == LINE_W-1
- filled_o  out  1  level; high once ROWS-1 complete lines are stored since last rst/sof

## Operation
- State: column counter col (0..LINE_W-1), row counter row (Y_W bits, wraps modulo 2^Y_W), fill counter fill (0..ROWS-1, saturating), ROWS-1 line stores mem[1..ROWS-1], each LINE_W x DATA_W.
- All line stores share one address = col. No separate read/write pointers.
- On accepted pixel (valid_i=1), with effective column c (0 if sof_i else col):
  - tap0 = data_i; tap k = mem[k][c] (old value, read-before-write) for k>=1.
  - Write mem[1][c] <= data_i; mem[k][c] <= old mem[k-1][c] for k>=2 (vertical shift).
  - Output registers load col_o=taps, x_o=c, y_o=effective row (0 if sof_i), eol_o=(c==LINE_W-1).
  - valid_o <= 1 iff effective fill == ROWS-1 (effective fill = 0 if sof_i).
  - If c == LINE_W-1: col <= 0, row <= row+1, fill <= min(fill+1, ROWS-1); else col <= c+1.
  - With sof_i, row/fill are first treated as 0, then updated by the rule above.
- valid_i=0: no counter, memory or output-data change; valid_o <= 0, eol_o <= 0 (gaps allowed anywhere, including mid-line).
- sof_i mid-line or mid-frame: restarts coordinates and fill immediately at that pixel; partial line is discarded logically. Memory is not cleared; stale data is masked because valid_o stays low until ROWS-1 new lines complete.
- filled_o = (fill == ROWS-1), combinational from the register.
- rst: col=0, row=0, fill=0, valid_o=0, eol_o=0, col_o=0, x_o=0, y_o=0, filled_o=0. Memory contents are not reset. A pixel presented in the rst cycle is dropped.
- No backpressure: downstream must accept every valid_o pulse.

## Timing
- Latency: 1 cycle from accepted pixel to valid_o/col_o.
- Throughput: 1 pixel/cycle sustained, no bubbles at line wrap.
- First valid_o after rst/sof: on the pixel at (x=0, y=ROWS-1), i.e. accepted pixel index (ROWS-1)*LINE_W, output one cycle later.
- filled_o rises the cycle after the last pixel of line ROWS-2 is accepted.
- Memory: single write, ROWS-1 asynchronous-or-same-cycle reads per store; inferable as distributed RAM. Read-before-write ordering is mandatory.

## Test plan
- Reset: assert rst 2 cycles with valid_i=1 -> all outputs 0, filled_o=0; first post-reset pixel gets x_o=0, y_o=0.
- Fill, LINE_W=4, ROWS=3, ramp data_i=0,1,2,... continuously with sof_i on first -> valid_o first high one cycle after pixel 8, col_o taps {8,4,0}, x_o=0, y_o=2; pixel 11 gives {11,7,3}, eol_o=1; 12 pulses valid over pixels 8..19.
- Gaps: same ramp with valid_i toggled 1,0,1,0 -> identical col_o/x_o/y_o sequence; valid_o only one cycle after each accepted pixel.
- Mid-frame restart: after 6 ramp pixels, send sof_i with data 100, then 101.. -> x_o resets to 0, y_o=0, filled_o drops to 0, no valid_o until pixel 108; it outputs taps {108,104,100}.
- Row wrap/eol: Y_W=2, run 5 lines after fill -> y_o sequence 2,3,0,1,... wraps; eol_o coincides only with x_o=3.
- Defaults (DATA_W=8, LINE_W=170, ROWS=3): random frame of 5 lines -> every col_o matches a reference model pixel-for-pixel; first valid at pixel index 340.

Source files
------------

// File: rtl/line_window_buffer.sv
// Multi-line pixel buffer: presents a vertical column of ROWS pixels at the
// current x for every accepted pixel, with frame restart and fill tracking.
module line_window_buffer #(
   parameter int DATA_W = 8,
   parameter int LINE_W = 170,
   parameter int ROWS   = 3,
   parameter int Y_W    = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       valid_i,
   input  logic                       sof_i,
   input  logic [DATA_W-1:0]          data_i,
   output logic                       valid_o,
   output logic [ROWS*DATA_W-1:0]     col_o,
   output logic [$clog2(LINE_W)-1:0]  x_o,
   output logic [Y_W-1:0]             y_o,
   output logic                       eol_o,
   output logic                       filled_o
);

   localparam int X_W = $clog2(LINE_W);
   localparam int F_W = $clog2(ROWS);
   localparam logic [X_W-1:0] X_LAST = X_W'(LINE_W - 1);
   localparam logic [F_W-1:0] F_FULL = F_W'(ROWS - 1);

   logic [X_W-1:0]         col_q, col_d, c;
   logic [Y_W-1:0]         row_q, row_d, r;
   logic [F_W-1:0]         fill_q, fill_d, f;
   logic                   last;
   logic [ROWS*DATA_W-1:0] taps;
   logic [DATA_W-1:0]      mem [1:ROWS-1][LINE_W];

   // sof_i forces the effective coordinates and fill to zero for this pixel
   always_comb begin
      c    = sof_i ? '0 : col_q;
      r    = sof_i ? '0 : row_q;
      f    = sof_i ? '0 : fill_q;
      last = (c == X_LAST);
      taps = '0;
      taps[DATA_W-1:0] = data_i;
      for (int k = 1; k < ROWS; k++) begin
         taps[k*DATA_W +: DATA_W] = mem[k][c];
      end
      col_d  = col_q;
      row_d  = row_q;
      fill_d = fill_q;
      if (valid_i) begin
         if (last) begin
            col_d  = '0;
            row_d  = r + Y_W'(1);
            fill_d = (f == F_FULL) ? f : f + F_W'(1);
         end else begin
            col_d  = c + X_W'(1);
            row_d  = r;
            fill_d = f;
         end
      end
   end

   // Vertical shift through the line stores; reads above see the old contents
   always_ff @(posedge clk) begin
      if (!rst && valid_i) begin
         mem[1][c] <= data_i;
         for (int k = 2; k < ROWS; k++) begin
            mem[k][c] <= mem[k-1][c];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_q   <= '0;
         row_q   <= '0;
         fill_q  <= '0;
         valid_o <= 1'b0;
         eol_o   <= 1'b0;
         col_o   <= '0;
         x_o     <= '0;
         y_o     <= '0;
      end else begin
         col_q   <= col_d;
         row_q   <= row_d;
         fill_q  <= fill_d;
         valid_o <= valid_i && (f == F_FULL);
         eol_o   <= valid_i && last;
         if (valid_i) begin
            col_o <= taps;
            x_o   <= c;
            y_o   <= r;
         end
      end
   end

   assign filled_o = (fill_q == F_FULL);

endmodule
